// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl
//
// Control FSM that turns the timer's BCD counter and seven-segment display
// into a start/stop/lap/clear stopwatch. It derives the counter's increment
// strobe from a prescaler, issues the counter clear, and can hold a captured
// lap value on the display while the counter keeps running underneath.
//
// Ports:
//   clk          - single rising-edge clock
//   reset        - asynchronous, active-low reset
//   start_stop   - debounced button level; rising edge toggles run/stop
//   lap          - debounced button level; rising edge freezes/releases display
//   clear        - debounced button level; rising edge zeroes the counter
//                  (only acted on while not running)
//   cnt_digits   - live counter digits {d3, d2, d1, d0}, 5 bits each
//   count_en     - one-cycle increment strobe to the BCD counter
//   count_clr    - one-cycle synchronous clear to the BCD counter
//   disp_digits  - digits forwarded to the seven-segment driver
//   run_led      - high while running (RUN or LAP)
//   state        - current state: IDLE=0, RUN=1, LAP=2, STOP=3, CLEAR=4

module stopwatch_ctrl #(
  parameter int TICK_DIV = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  input  logic [19:0] cnt_digits,
  output logic        count_en,
  output logic        count_clr,
  output logic [19:0] disp_digits,
  output logic        run_led,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    STOP  = 3'd3,
    CLEAR = 3'd4
  } stateT;

  localparam logic [19:0] TICK_MAX = 20'(TICK_DIV - 1);

  stateT       state_q;
  stateT       state_d;
  logic        ssPrev_q;
  logic        lapPrev_q;
  logic        clrPrev_q;
  logic [19:0] pre_q;
  logic [19:0] pre_d;
  logic [19:0] lapReg_q;
  logic        freeze_q;
  logic        runLed_q;
  logic        countEn_q;
  logic        countClr_q;

  logic        ssEdge;
  logic        lapEdge;
  logic        clrEdge;
  logic        captureLap;
  logic        curRunning;
  logic        nextRunning;
  logic        preAdvance;
  logic        tickHit;

  // Rising-edge detect on each button. The prev registers come out of reset
  // high, so a button already held when reset is released never fires.
  assign ssEdge  = start_stop & ~ssPrev_q;
  assign lapEdge = lap        & ~lapPrev_q;
  assign clrEdge = clear      & ~clrPrev_q;

  // Next-state selection. Within each state the legal edges are tested in
  // clear > start_stop > lap order, so the highest-priority edge that
  // means something here wins and the rest are dropped. An edge that is
  // illegal in the current state (e.g. clear while running) does not block
  // a lower-priority legal one.
  always_comb begin
    state_d    = state_q;
    captureLap = 1'b0;
    case (state_q)
      IDLE: begin
        if (clrEdge) begin
          state_d = CLEAR;
        end else if (ssEdge) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (ssEdge) begin
          state_d = STOP;
        end else if (lapEdge) begin
          state_d    = LAP;
          captureLap = 1'b1;
        end
      end
      LAP: begin
        if (ssEdge) begin
          state_d = STOP;
        end else if (lapEdge) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (clrEdge) begin
          state_d = CLEAR;
        end else if (ssEdge) begin
          state_d = RUN;
        end
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler. It only advances on edges where the watch is running both
  // before and after the edge: the edge that enters RUN starts from the
  // held phase without counting, and the edge that stops the watch does not
  // count either, which is what lets a stop on the terminal count swallow
  // that tick while keeping the phase for the resume.
  always_comb begin
    curRunning  = (state_q == RUN) || (state_q == LAP);
    nextRunning = (state_d == RUN) || (state_d == LAP);
    preAdvance  = curRunning && nextRunning;
    tickHit     = preAdvance && (pre_q == TICK_MAX);
    pre_d       = pre_q;
    if ((state_d == CLEAR) && (state_q != CLEAR)) begin
      pre_d = 20'd0;
    end else if (tickHit) begin
      pre_d = 20'd0;
    end else if (preAdvance) begin
      pre_d = pre_q + 20'd1;
    end
  end

  // All state and registered outputs. The outputs are computed from the
  // next state so they line up with the state register in the cycle after
  // the button edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ssPrev_q   <= 1'b1;
      lapPrev_q  <= 1'b1;
      clrPrev_q  <= 1'b1;
      pre_q      <= 20'd0;
      lapReg_q   <= 20'd0;
      freeze_q   <= 1'b0;
      runLed_q   <= 1'b0;
      countEn_q  <= 1'b0;
      countClr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ssPrev_q   <= start_stop;
      lapPrev_q  <= lap;
      clrPrev_q  <= clear;
      pre_q      <= pre_d;
      if (captureLap) begin
        lapReg_q <= cnt_digits;
      end
      freeze_q   <= (state_d == LAP);
      runLed_q   <= (state_d == RUN) || (state_d == LAP);
      countEn_q  <= tickHit;
      countClr_q <= (state_d == CLEAR);
    end
  end

  assign count_en    = countEn_q;
  assign count_clr   = countClr_q;
  assign run_led     = runLed_q;
  assign state       = state_q;
  assign disp_digits = freeze_q ? lapReg_q : cnt_digits;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl
//
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4. Each driven cycle
// pushes its expected outputs onto a scoreboard queue; after the clock edge
// the entry is popped and compared against the DUT outputs.

module tb_stopwatch_ctrl;

  localparam int TICK = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_LAP   = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;

  logic        clk;
  logic        reset;
  logic        startStop;
  logic        lapBtn;
  logic        clearBtn;
  logic [19:0] cntDigits;
  logic        countEn;
  logic        countClr;
  logic [19:0] dispDigits;
  logic        runLed;
  logic [2:0]  stateOut;

  typedef struct packed {
    logic [2:0]  st;
    logic        run;
    logic        en;
    logic        clr;
    logic [19:0] disp;
  } expT;

  expT   sbQ[$];
  string tagQ[$];

  int          vectors;
  int          miscompares;
  int          edgeNo;
  int          nextTick;
  int          remaining;
  logic [2:0]  prevExp;
  logic [19:0] live;
  logic [19:0] lapVal;
  logic        lastExpEn;

  stopwatch_ctrl #(.TICK_DIV(TICK)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_stop  (startStop),
    .lap         (lapBtn),
    .clear       (clearBtn),
    .cnt_digits  (cntDigits),
    .count_en    (countEn),
    .count_clr   (countClr),
    .disp_digits (dispDigits),
    .run_led     (runLed),
    .state       (stateOut)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic isRunning(input logic [2:0] s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

  // Drive one cycle of button levels plus the live digits, push the expected
  // outputs for after the coming edge, then pop and compare once it passed.
  // Tick timing follows the externally visible rules: first tick TICK edges
  // after entering RUN from IDLE/CLEAR, every TICK edges while running, and
  // on resume the remaining distance plus one edge.
  task automatic applyStimulus(input logic ss, input logic lp, input logic cl,
                               input logic [2:0] expSt, input string tag);
    expT item;
    int  e;
    @(negedge clk);
    startStop = ss;
    lapBtn    = lp;
    clearBtn  = cl;
    cntDigits = live;
    e = edgeNo + 1;
    item.en = 1'b0;
    if (isRunning(prevExp) && isRunning(expSt)) begin
      if (e == nextTick) begin
        item.en  = 1'b1;
        nextTick = nextTick + TICK;
      end
    end else if (!isRunning(prevExp) && isRunning(expSt)) begin
      if (prevExp == S_STOP) nextTick = e + remaining + 1;
      else                   nextTick = e + TICK;
    end else if (isRunning(prevExp) && !isRunning(expSt)) begin
      remaining = nextTick - e;
    end
    if ((prevExp == S_RUN) && (expSt == S_LAP)) lapVal = live;
    item.st   = expSt;
    item.run  = isRunning(expSt);
    item.clr  = (expSt == S_CLEAR);
    item.disp = (expSt == S_LAP) ? lapVal : live;
    prevExp   = expSt;
    lastExpEn = item.en;
    sbQ.push_back(item);
    tagQ.push_back(tag);
    @(posedge clk);
    edgeNo++;
    #1;
    if (sbQ.size() == 0) begin
      checkOutput({tag, ".sbEmpty"}, 32'd0, 32'd1);
    end else begin
      string t;
      item = sbQ.pop_front();
      t    = tagQ.pop_front();
      checkOutput({t, ".state"},  32'(stateOut),   32'(item.st));
      checkOutput({t, ".runLed"}, 32'(runLed),     32'(item.run));
      checkOutput({t, ".cntEn"},  32'(countEn),    32'(item.en));
      checkOutput({t, ".cntClr"}, 32'(countClr),   32'(item.clr));
      checkOutput({t, ".disp"},   32'(dispDigits), 32'(item.disp));
    end
    live = live + 20'd1;
  endtask

  // Compare every output against its reset value while reset is held.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".state"},  32'(stateOut),   32'(S_IDLE));
    checkOutput({tag, ".runLed"}, 32'(runLed),     32'd0);
    checkOutput({tag, ".cntEn"},  32'(countEn),    32'd0);
    checkOutput({tag, ".cntClr"}, 32'(countClr),   32'd0);
    checkOutput({tag, ".disp"},   32'(dispDigits), 32'(cntDigits));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edgeNo      = 0;
    nextTick    = 0;
    remaining   = 0;
    prevExp     = S_IDLE;
    live        = 20'h0ABCD;
    lapVal      = 20'd0;
    lastExpEn   = 1'b0;
    reset       = 1'b0;
    startStop   = 1'b0;
    lapBtn      = 1'b0;
    clearBtn    = 1'b0;
    cntDigits   = live;

    // Reset state, then release with buttons low and start.
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    reset = 1'b1;
    applyStimulus(0, 0, 0, S_IDLE, "idle");
    applyStimulus(0, 0, 0, S_IDLE, "idle");
    applyStimulus(1, 0, 0, S_RUN, "start");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, S_RUN, "run");

    // Stop with the prescaler at 2, idle in STOP, resume.
    applyStimulus(1, 0, 0, S_STOP, "stop");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, S_STOP, "stopped");
    applyStimulus(1, 0, 0, S_RUN, "resume");
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, S_RUN, "resumed");

    // Lap freeze on 0x00123 while the digits keep ramping.
    live = 20'h00123;
    applyStimulus(0, 1, 0, S_LAP, "lap");
    for (int i = 0; i < 9; i++) applyStimulus(0, 0, 0, S_LAP, "lapHold");
    applyStimulus(0, 1, 0, S_RUN, "unlap");
    applyStimulus(0, 0, 0, S_RUN, "live");
    applyStimulus(0, 0, 0, S_RUN, "live");

    // Clear ignored while running, honoured in STOP.
    applyStimulus(0, 0, 1, S_RUN, "clrInRun");
    applyStimulus(0, 0, 0, S_RUN, "run");
    applyStimulus(1, 0, 0, S_STOP, "stop");
    applyStimulus(0, 0, 0, S_STOP, "stopped");
    applyStimulus(0, 0, 1, S_CLEAR, "clear");
    applyStimulus(0, 0, 1, S_IDLE, "clrHeld");
    applyStimulus(0, 0, 0, S_IDLE, "idle");
    applyStimulus(1, 0, 0, S_RUN, "startAfterClr");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, S_RUN, "run");

    // Simultaneous edges.
    applyStimulus(1, 0, 0, S_STOP, "stop");
    applyStimulus(0, 0, 0, S_STOP, "stopped");
    applyStimulus(1, 0, 1, S_CLEAR, "clrAndSs");
    applyStimulus(0, 0, 0, S_IDLE, "idle");
    applyStimulus(1, 0, 0, S_RUN, "start");
    applyStimulus(0, 0, 0, S_RUN, "run");
    applyStimulus(0, 0, 0, S_RUN, "run");
    applyStimulus(0, 1, 0, S_LAP, "lap2");
    applyStimulus(0, 0, 0, S_LAP, "lapHold");
    applyStimulus(0, 0, 0, S_LAP, "lapHold");
    applyStimulus(0, 1, 0, S_RUN, "unlap2");
    applyStimulus(0, 0, 0, S_RUN, "run");
    applyStimulus(1, 1, 0, S_STOP, "ssAndLap");
    checkOutput("ssAndLap.lapReg", 32'(dut.lapReg_q), 32'(lapVal));
    applyStimulus(0, 0, 0, S_STOP, "stopped");

    // start_stop held high through reset release must not start the watch.
    @(negedge clk);
    reset     = 1'b0;
    startStop = 1'b1;
    #1;
    checkResetOutputs("heldReset");
    prevExp = S_IDLE;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, S_IDLE, "heldSs");
    applyStimulus(0, 0, 0, S_IDLE, "idle");
    applyStimulus(1, 0, 0, S_RUN, "start");
    applyStimulus(0, 0, 0, S_RUN, "run");
    applyStimulus(0, 1, 0, S_LAP, "lap3");

    // Reset inside LAP, right after a tick edge so a strobe is pending.
    lastExpEn = 1'b0;
    for (int i = 0; i < 2 * TICK && !lastExpEn; i++) begin
      applyStimulus(0, 0, 0, S_LAP, "lapToTick");
    end
    checkOutput("tickBeforeReset", 32'(countEn), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkResetOutputs("midLapReset");
    prevExp = S_IDLE;
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, 0, 0, S_IDLE, "postReset");
    applyStimulus(0, 0, 0, S_IDLE, "postReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
